// File: rtl/button_conditioner.sv
// Button/switch input conditioner: 2-flop synchronisers, per-button debounce FSM with press and
// release pulses, and a switch snapshot on every press pulse. Macro AUTO_REPEAT_EN adds auto-repeat.
module button_conditioner #(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned N_SW            = 10,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_CYCLES   = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] BTN_IN,
  input  logic [N_SW-1:0]  SWITCH_IN,
  output logic [N_BTN-1:0] BTN_LEVEL,
  output logic [N_BTN-1:0] BTN_PULSE,
  output logic [N_BTN-1:0] BTN_RELEASE,
  output logic [N_SW-1:0]  SWITCH_OUT
);

  typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StReleaseWait} state_e;

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RpLast = CNT_W'(REPEAT_CYCLES - 1);
`endif

  if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W) ||
      REPEAT_CYCLES < 1 || longint'(REPEAT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_params
    $error("button_conditioner: DEBOUNCE_CYCLES/REPEAT_CYCLES out of range for CNT_W");
  end

  logic [N_BTN-1:0] r_btn_s1, r_btn_s2;
  logic [N_SW-1:0]  r_sw_s1, r_sw_s2;
  logic [N_SW-1:0]  r_sw_out;
  logic [N_BTN-1:0] w_set;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_sw_out <= '0;
    end else begin
      r_btn_s1 <= BTN_IN;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= SWITCH_IN;
      r_sw_s2  <= r_sw_s1;
      // One shared snapshot for every pulse set on this edge
      if (|w_set) r_sw_out <= r_sw_s2;
    end
  end

  assign SWITCH_OUT = r_sw_out;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level, r_pulse, r_release;
    logic             w_bs, w_accept;

    assign w_bs     = r_btn_s2[gi];
    assign w_accept = (r_state == StPressWait) && w_bs && (r_cnt == DbLast);

`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0] r_rpt;

    assign w_set[gi] = w_accept || ((r_state == StHeld) && w_bs && (r_rpt == RpLast));

    // Counts only while staying in HELD; any other cycle restarts the repeat period
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_rpt <= '0;
      end else if ((r_state == StHeld) && w_bs) begin
        r_rpt <= (r_rpt == RpLast) ? '0 : r_rpt + CNT_W'(1);
      end else begin
        r_rpt <= '0;
      end
    end
`else
    assign w_set[gi] = w_accept;
`endif

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_state   <= StIdle;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_pulse   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_pulse   <= w_set[gi];
        r_release <= 1'b0;
        unique case (r_state)
          StIdle: begin
            if (w_bs) begin
              r_state <= StPressWait;
              r_cnt   <= '0;
            end
          end
          StPressWait: begin
            if (!w_bs) begin
              r_state <= StIdle;
            end else if (w_accept) begin
              r_state <= StHeld;
              r_level <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          StHeld: begin
            if (!w_bs) begin
              r_state <= StReleaseWait;
              r_cnt   <= '0;
            end
          end
          StReleaseWait: begin
            if (w_bs) begin
              r_state <= StHeld;
            end else if (r_cnt == DbLast) begin
              r_state   <= StIdle;
              r_level   <= 1'b0;
              r_release <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end

    assign BTN_LEVEL[gi]   = r_level;
    assign BTN_PULSE[gi]   = r_pulse;
    assign BTN_RELEASE[gi] = r_release;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner against a run-length reference model.
// Define AUTO_REPEAT_EN consistently for bench and RTL to exercise auto-repeat.
module tb_button_conditioner;

  localparam int NBtn = 3;
  localparam int NSw  = 10;
  localparam int Db   = 4;
  localparam int Rp   = 8;
`ifdef AUTO_REPEAT_EN
  localparam int ExpT6 = 4;
`else
  localparam int ExpT6 = 1;
`endif

  logic            CLK = 1'b0;
  logic            RST;
  logic [NBtn-1:0] BTN_IN;
  logic [NSw-1:0]  SWITCH_IN;
  logic [NBtn-1:0] BTN_LEVEL, BTN_PULSE, BTN_RELEASE;
  logic [NSw-1:0]  SWITCH_OUT;

  button_conditioner #(
    .N_BTN          (NBtn),
    .N_SW           (NSw),
    .CNT_W          (16),
    .DEBOUNCE_CYCLES(Db),
    .REPEAT_CYCLES  (Rp)
  ) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .BTN_IN     (BTN_IN),
    .SWITCH_IN  (SWITCH_IN),
    .BTN_LEVEL  (BTN_LEVEL),
    .BTN_PULSE  (BTN_PULSE),
    .BTN_RELEASE(BTN_RELEASE),
    .SWITCH_OUT (SWITCH_OUT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
  endtask

  // Reference model: two-stage sample delay, then a level flips once the delayed input has
  // disagreed with it for Db+1 consecutive samples.
  logic [NBtn-1:0] m_b1, m_b2, m_level, m_pulse, m_rel;
  logic [NSw-1:0]  m_s1, m_s2, m_swout;
  int              m_run[NBtn];
`ifdef AUTO_REPEAT_EN
  int              m_rep[NBtn];
  logic [NBtn-1:0] m_prev;
`endif

  task automatic model_reset();
    m_b1 = '0; m_b2 = '0; m_level = '0; m_pulse = '0; m_rel = '0;
    m_s1 = '0; m_s2 = '0; m_swout = '0;
    for (int i = 0; i < NBtn; i++) m_run[i] = 0;
`ifdef AUTO_REPEAT_EN
    for (int i = 0; i < NBtn; i++) m_rep[i] = 0;
    m_prev = '0;
`endif
  endtask

  task automatic model_step();
    logic [NBtn-1:0] bs;
    bs = m_b2;
    m_pulse = '0;
    m_rel   = '0;
    for (int i = 0; i < NBtn; i++) begin
      if (bs[i] != m_level[i]) begin
`ifdef AUTO_REPEAT_EN
        m_rep[i] = 0;
`endif
        m_run[i]++;
        if (m_run[i] == Db + 1) begin
          m_level[i] = bs[i];
          m_run[i]   = 0;
          if (bs[i]) m_pulse[i] = 1'b1;
          else m_rel[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
`ifdef AUTO_REPEAT_EN
        // A held sample counts only if the previous sample was held as well
        if (bs[i] && m_prev[i]) begin
          m_rep[i]++;
          if (m_rep[i] == Rp) begin
            m_pulse[i] = 1'b1;
            m_rep[i]   = 0;
          end
        end else begin
          m_rep[i] = 0;
        end
`endif
      end
    end
    if (|m_pulse) m_swout = m_s2;
`ifdef AUTO_REPEAT_EN
    m_prev = bs;
`endif
    m_b2 = m_b1; m_b1 = BTN_IN;
    m_s2 = m_s1; m_s1 = SWITCH_IN;
  endtask

  int cyc;
  int p_cnt[NBtn], r_cnt[NBtn], p_first[NBtn], r_first[NBtn];

  task automatic mark();
    cyc = 0;
    for (int i = 0; i < NBtn; i++) begin
      p_cnt[i] = 0; r_cnt[i] = 0; p_first[i] = 0; r_first[i] = 0;
    end
  endtask

  // Called at a negedge: drive, clock, then compare against the model at the next negedge
  task automatic cycle(input logic [NBtn-1:0] b, input logic [NSw-1:0] s);
    BTN_IN    = b;
    SWITCH_IN = s;
    @(posedge CLK);
    model_step();
    cyc++;
    @(negedge CLK);
    chk("level", 32'(BTN_LEVEL), 32'(m_level));
    chk("pulse", 32'(BTN_PULSE), 32'(m_pulse));
    chk("release", 32'(BTN_RELEASE), 32'(m_rel));
    chk("switch_out", 32'(SWITCH_OUT), 32'(m_swout));
    for (int i = 0; i < NBtn; i++) begin
      if (BTN_PULSE[i]) begin
        p_cnt[i]++;
        if (p_first[i] == 0) p_first[i] = cyc;
      end
      if (BTN_RELEASE[i]) begin
        r_cnt[i]++;
        if (r_first[i] == 0) r_first[i] = cyc;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_level"}, 32'(BTN_LEVEL), 32'd0);
    chk({tag, "_pulse"}, 32'(BTN_PULSE), 32'd0);
    chk({tag, "_release"}, 32'(BTN_RELEASE), 32'd0);
    chk({tag, "_switch"}, 32'(SWITCH_OUT), 32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    #1;
    check_zero("rnd_rst");
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  logic [NBtn-1:0] rb;
  logic [NSw-1:0]  rs;

  initial begin
    // 1: reset with everything asserted, then full-width accept
    RST = 1'b1; BTN_IN = 3'b111; SWITCH_IN = 10'h3FF;
    model_reset();
    @(negedge CLK);
    check_zero("t1_rst");
    RST = 1'b0;
    mark();
    repeat (10) cycle(3'b111, 10'h3FF);
    for (int i = 0; i < NBtn; i++) chk("t1_pulse_edge", 32'(p_first[i]), 32'(3 + Db));
    chk("t1_pulse_count", 32'(p_cnt[1]), 32'd1);
    chk("t1_switch", 32'(SWITCH_OUT), 32'h3FF);
    repeat (12) cycle(3'b000, 10'h005);

    // 2: clean press and release on button 0
    mark();
    repeat (20) cycle(3'b001, 10'h005);
    chk("t2_level", 32'(BTN_LEVEL[0]), 32'd1);
    chk("t2_pulse_edge", 32'(p_first[0]), 32'(3 + Db));
    repeat (12) cycle(3'b000, 10'h005);
    chk("t2_release_edge", 32'(r_first[0]), 32'(21 + 2 + Db));
    chk("t2_switch", 32'(SWITCH_OUT), 32'h005);

    // 3: press shorter than the debounce window
    mark();
    repeat (3) cycle(3'b010, 10'h2A0);
    repeat (10) cycle(3'b000, 10'h2A0);
    chk("t3_pulses", 32'(p_cnt[1]), 32'd0);
    chk("t3_level", 32'(BTN_LEVEL[1]), 32'd0);
    chk("t3_switch", 32'(SWITCH_OUT), 32'h005);

    // 4: accepted press, bouncy release, then held again
    mark();
    repeat (10) cycle(3'b100, 10'h0F0);
    for (int i = 0; i < 10; i++) cycle(((i / 2) % 2 == 1) ? 3'b100 : 3'b000, 10'h0F0);
    repeat (10) cycle(3'b100, 10'h0F0);
    chk("t4_pulses", 32'(p_cnt[2]), 32'd1);
    chk("t4_releases", 32'(r_cnt[2]), 32'd0);
    chk("t4_level", 32'(BTN_LEVEL[2]), 32'd1);

    // 5: asynchronous reset during button 1 PRESS_WAIT while button 2 is held
    repeat (3) cycle(3'b110, 10'h0F0);
    chk("t5_pre_level", 32'(BTN_LEVEL), 32'b100);
    chk("t5_pre_switch", 32'(SWITCH_OUT), 32'h0F0);
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    check_zero("t5_async");
    @(negedge CLK);
    RST = 1'b0;
    mark();
    repeat (8) cycle(3'b110, 10'h111);
    chk("t5_pulse_edge1", 32'(p_first[1]), 32'(3 + Db));
    chk("t5_pulse_edge2", 32'(p_first[2]), 32'(3 + Db));
    chk("t5_switch", 32'(SWITCH_OUT), 32'h111);
    repeat (14) cycle(3'b000, 10'h111);

    // 6: long hold, auto-repeat pulses only when enabled
    mark();
    repeat (7 + 30) cycle(3'b001, 10'h1C3);
    chk("t6_pulses", 32'(p_cnt[0]), 32'(ExpT6));
    chk("t6_first", 32'(p_first[0]), 32'(3 + Db));
    repeat (14) cycle(3'b000, 10'h1C3);

    // Random phase with occasional resets
    rb = '0;
    rs = 10'h1C3;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      for (int i = 0; i < NBtn; i++) if ($urandom_range(0, 6) == 0) rb[i] = ~rb[i];
      if ($urandom_range(0, 3) == 0) rs = 10'($urandom);
      cycle(rb, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
